// File: rtl/keccak_squeeze_out.sv
// keccak_squeeze_out
// ------------------
// Squeeze-phase serialiser for a Keccak core. Each time the permutation
// finishes, the rate portion of the state is captured and streamed out
// lane by lane over a valid/ready handshake. Another permutation is
// requested whenever a block is exhausted and more output words are still
// owed. The squeeze ends after the requested number of words.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-low reset (0 = reset)
//   start_i       pulse in IDLE: begin a squeeze of out_len_i words
//   out_len_i     number of WORD_W words to emit (0 = finish immediately)
//   rate_i        rate bits of the current state, lane 0 in the low bits
//   rate_valid_i  pulse: permutation finished, rate_i valid
//   perm_req_o    pulse: run one more permutation
//   data_o        output word
//   valid_o       data_o valid
//   ready_i       consumer accepts data_o
//   last_o        data_o is the final word of the squeeze
//   busy_o        squeeze in progress
//   done_o        pulse: squeeze complete
module keccak_squeeze_out #(
    parameter int RATE_W = 1088,
    parameter int WORD_W = 64,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  out_len_i,
    input  logic [RATE_W-1:0] rate_i,
    input  logic              rate_valid_i,
    output logic              perm_req_o,
    output logic [WORD_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int WPB    = RATE_W / WORD_W;
    localparam int WIDX_W = (WPB > 1) ? $clog2(WPB) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BLOCK,
        EMIT,
        DONE
    } state_t;

    state_t             state_q,     state_d;
    logic [RATE_W-1:0]  rate_buf_q,  rate_buf_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [WIDX_W-1:0]  widx_q,      widx_d;

    logic accept;

    // Outputs decode registered state only; valid_o never depends on ready_i.
    assign valid_o = (state_q == EMIT);
    assign data_o  = rate_buf_q[WORD_W-1:0];
    assign last_o  = (state_q == EMIT) && (remaining_q == LEN_W'(1));
    assign busy_o  = (state_q != IDLE);
    assign done_o  = (state_q == DONE);
    assign accept  = valid_o && ready_i;

    always_comb begin
        state_d     = state_q;
        rate_buf_d  = rate_buf_q;
        remaining_d = remaining_q;
        widx_d      = widx_q;
        perm_req_o  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (out_len_i != '0) begin
                        remaining_d = out_len_i;
                        state_d     = WAIT_BLOCK;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            WAIT_BLOCK: begin
                if (rate_valid_i) begin
                    rate_buf_d = rate_i;
                    widx_d     = '0;
                    state_d    = EMIT;
                end
            end

            EMIT: begin
                if (accept) begin
                    rate_buf_d  = rate_buf_q >> WORD_W;
                    remaining_d = remaining_q - LEN_W'(1);
                    widx_d      = widx_q + WIDX_W'(1);
                    // Finishing the squeeze takes priority over the block
                    // boundary, so no surplus permutation is requested.
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end else if (widx_q == WIDX_W'(WPB - 1)) begin
                        perm_req_o = 1'b1;
                        state_d    = WAIT_BLOCK;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            rate_buf_q  <= '0;
            remaining_q <= '0;
            widx_q      <= '0;
        end else begin
            state_q     <= state_d;
            rate_buf_q  <= rate_buf_d;
            remaining_q <= remaining_d;
            widx_q      <= widx_d;
        end
    end

endmodule

// File: tb/tb_keccak_squeeze_out.sv
// tb_keccak_squeeze_out
// ---------------------
// Self-checking bench for keccak_squeeze_out. Expected words come from a
// table of blocks: output word n is lane (n mod WPB) of block (n / WPB).
// Permutation requests, last flags and the completion pulse are derived
// from the word count alone.
module tb_keccak_squeeze_out;

    localparam int RATE_W = 1088;
    localparam int WORD_W = 64;
    localparam int LEN_W  = 16;
    localparam int WPB    = RATE_W / WORD_W;
    localparam int NBLK   = 4;

    logic              clk;
    logic              rst;
    logic              start_i;
    logic [LEN_W-1:0]  out_len_i;
    logic [RATE_W-1:0] rate_i;
    logic              rate_valid_i;
    logic              perm_req_o;
    logic [WORD_W-1:0] data_o;
    logic              valid_o;
    logic              ready_i;
    logic              last_o;
    logic              busy_o;
    logic              done_o;

    logic [RATE_W-1:0] blocks [0:NBLK-1];
    int n_cmp = 0;
    int n_bad = 0;

    keccak_squeeze_out #(
        .RATE_W(RATE_W),
        .WORD_W(WORD_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .out_len_i   (out_len_i),
        .rate_i      (rate_i),
        .rate_valid_i(rate_valid_i),
        .perm_req_o  (perm_req_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .last_o      (last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports it when observed != expected.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Block contents: 0 random, 1 lane k = k+1, 2 lane k = {block,k},
    // 3 random with lane 0 of block 0 fixed.
    task automatic fillBlocks(input int kind);
        logic [RATE_W-1:0] tmp;
        logic [63:0] w;
        for (int b = 0; b < NBLK; b++) begin
            for (int k = 0; k < WPB; k++) begin
                case (kind)
                    1:       w = 64'(k + 1);
                    2:       w = {32'(b), 32'(k)};
                    default: w = {$urandom, $urandom};
                endcase
                if (kind == 3 && b == 0 && k == 0) w = 64'h0123_4567_89AB_CDEF;
                tmp[k*WORD_W +: WORD_W] = w;
            end
            blocks[b] = tmp;
        end
    endtask

    function automatic logic [63:0] modelWord(input int n);
        logic [RATE_W-1:0] tmp;
        tmp = blocks[n / WPB];
        return tmp[(n % WPB)*WORD_W +: WORD_W];
    endfunction

    // Run one squeeze of len words. mode 0: ready always 1; 1: random
    // ready; 2: ready pattern 1,0,0,1,0,1,1,1 then 1. Spurious start_i and
    // rate_valid_i pulses are injected while the squeeze is in progress.
    task automatic applyStimulus(input int len, input int mode);
        int  acc, perms, blk, delay, pi, acc_cyc, exp_perms;
        bit  need, was_wait, fin, prev_valid, prev_acc, exp_perm;
        logic [63:0] prev_data;
        logic prev_last;
        bit pat [0:7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        acc = 0; perms = 0; blk = 0; pi = 0; acc_cyc = -10;
        need = (len != 0); fin = 0; prev_valid = 0; prev_acc = 0;
        prev_data = '0; prev_last = 0;
        delay = $urandom_range(0, 3);
        exp_perms = (len > 0) ? (len - 1) / WPB : 0;
        $display("[TB] squeeze len=%0d mode=%0d", len, mode);

        @(negedge clk);
        start_i = 1'b1; out_len_i = LEN_W'(len); rate_valid_i = 1'b0; ready_i = 1'b1;

        for (int cyc = 0; cyc < 800 && !fin; cyc++) begin
            @(negedge clk);
            start_i = 1'b0; rate_valid_i = 1'b0;
            was_wait = need;
            if (need) begin
                if (delay == 0) begin
                    rate_i = blocks[blk];
                    rate_valid_i = 1'b1;
                    blk++;
                    need = 0;
                end else begin
                    delay--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                rate_i = {34{$urandom}};
                rate_valid_i = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) begin
                start_i = 1'b1;
                out_len_i = LEN_W'($urandom_range(1, 60));
            end
            case (mode)
                0:       ready_i = 1'b1;
                1:       ready_i = ($urandom_range(0, 2) != 0);
                default: ready_i = (pi < 8) ? pat[pi] : 1'b1;
            endcase
            #1;
            if (was_wait) checkOutput("wait_valid", 64'(valid_o), 64'd0);
            if (valid_o) begin
                if (acc >= len) begin
                    checkOutput("extra_word", 64'(acc), 64'(len));
                end else begin
                    checkOutput("data", data_o, modelWord(acc));
                    checkOutput("last", 64'(last_o), 64'(acc == len - 1));
                end
                if (prev_valid && !prev_acc) begin
                    checkOutput("hold_data", data_o, prev_data);
                    checkOutput("hold_last", 64'(last_o), 64'(prev_last));
                end
            end
            if (valid_o && ready_i) begin
                exp_perm = ((acc + 1) % WPB == 0) && (acc + 1 != len);
                checkOutput("perm_on_accept", 64'(perm_req_o), 64'(exp_perm));
                if (perm_req_o) begin
                    need = 1;
                    perms++;
                    delay = $urandom_range(0, 3);
                end
                acc++;
                acc_cyc = cyc;
            end else begin
                checkOutput("perm_idle", 64'(perm_req_o), 64'd0);
            end
            prev_valid = valid_o;
            prev_acc   = valid_o && ready_i;
            prev_data  = data_o;
            prev_last  = last_o;
            if (valid_o) pi++;
            if (done_o) begin
                fin = 1;
                checkOutput("accept_count", 64'(acc), 64'(len));
                checkOutput("perm_count", 64'(perms), 64'(exp_perms));
                checkOutput("busy_in_done", 64'(busy_o), 64'd1);
                if (len > 0) checkOutput("done_latency", 64'(cyc), 64'(acc_cyc + 1));
            end
        end
        if (!fin) checkOutput("timeout", 64'd0, 64'd1);

        // start_i during the DONE cycle must be ignored.
        rate_valid_i = 1'b0; ready_i = 1'b0;
        start_i = 1'b1; out_len_i = LEN_W'(3);
        @(negedge clk);
        start_i = 1'b0;
        #1;
        checkOutput("idle_busy", 64'(busy_o), 64'd0);
        checkOutput("idle_done", 64'(done_o), 64'd0);
        checkOutput("idle_valid", 64'(valid_o), 64'd0);
    endtask

    initial begin
        rst = 1'b0; start_i = 1'b0; out_len_i = '0; rate_i = '0;
        rate_valid_i = 1'b0; ready_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_valid", 64'(valid_o), 64'd0);
        checkOutput("rst_last", 64'(last_o), 64'd0);
        checkOutput("rst_perm", 64'(perm_req_o), 64'd0);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_done", 64'(done_o), 64'd0);
        checkOutput("rst_data", data_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Reset in the middle of EMIT, on the third word
        fillBlocks(0);
        @(negedge clk);
        start_i = 1'b1; out_len_i = LEN_W'(10);
        @(negedge clk);
        start_i = 1'b0; rate_i = blocks[0]; rate_valid_i = 1'b1;
        @(negedge clk);
        rate_valid_i = 1'b0; ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("mid_word3", data_o, modelWord(2));
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("mid_rst_valid", 64'(valid_o), 64'd0);
        checkOutput("mid_rst_busy", 64'(busy_o), 64'd0);
        checkOutput("mid_rst_done", 64'(done_o), 64'd0);
        checkOutput("mid_rst_data", data_o, 64'd0);
        rst = 1'b1; ready_i = 1'b0;
        fillBlocks(0);
        applyStimulus(2, 0);

        // Single word
        fillBlocks(3);
        applyStimulus(1, 0);

        // SHA3-256 digest
        fillBlocks(1);
        applyStimulus(4, 0);

        // SHAKE multi-block, plus exact block-multiple lengths
        fillBlocks(2);
        applyStimulus(40, 0);
        applyStimulus(17, 0);
        applyStimulus(34, 1);

        // Backpressure
        fillBlocks(0);
        applyStimulus(5, 2);

        // Zero length
        applyStimulus(0, 0);

        // Randomised squeezes
        for (int r = 0; r < 6; r++) begin
            fillBlocks(0);
            applyStimulus($urandom_range(1, 68), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keccak_squeeze_out.md
# keccak_squeeze_out

Output-side companion to the Keccak absorb controller. It serialises the squeeze phase. On each completed permutation it captures the RATE_W-bit rate portion of the state, streams it out as WORD_W-bit words over a valid/ready handshake, and requests more permutations until the requested output length has been delivered. It sits between the Keccak round datapath (state register + round counter) and the downstream consumer of digest/XOF words.

## Interface
- RATE_W, 1088: rate in bits; must be a multiple of WORD_W.
- WORD_W, 64: output word width (one Keccak lane).
- LEN_W, 16: width of the output-length field, in words.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
- start_i  input  1  one-cycle pulse: begin a squeeze of out_len_i words.
- out_len_i  input  LEN_W  number of WORD_W words to emit; sampled only with start_i in IDLE.
- rate_i  input  RATE_W  rate bits of the current state; bit 0 = lane 0 bit 0.
- rate_valid_i  input  1  pulse: permutation finished, rate_i valid this cycle.
- perm_req_o  output  1  one-cycle pulse: run one more permutation (no absorb).
- data_o  output  WORD_W  output word.
- valid_o  output  1  data_o valid.
- ready_i  input  1  consumer accepts data_o.
- last_o  output  1  the current data_o is the final word of the squeeze.
- busy_o  output  1  squeeze in progress (any state other than IDLE).
- done_o  output  1  one-cycle pulse: squeeze complete.

## Operation
- WPB = RATE_W/WORD_W words per block (17 at defaults).
- Registers:
  - buf: RATE_W shift register.
  - remaining: LEN_W down-counter.
  - widx: word index within the block, clog2(WPB) bits.
  - state.
- IDLE:
  - start_i=1, out_len_i≠0 → remaining←out_len_i, go WAIT_BLOCK.
  - start_i=1, out_len_i=0 → go DONE (no words emitted).
  - Otherwise stay in IDLE.
- WAIT_BLOCK: on rate_valid_i=1 → buf←rate_i, widx←0, go EMIT. Otherwise stay.
- EMIT:
  - valid_o=1, data_o=buf[WORD_W-1:0], last_o=(remaining==1).
  - On accept (valid_o && ready_i): buf←buf>>WORD_W, remaining←remaining-1, widx←widx+1. Then, checked in order:
    - remaining==1 → go DONE.
    - else widx==WPB-1 → perm_req_o=1 this same cycle, go WAIT_BLOCK.
    - else stay in EMIT.
- DONE: done_o=1 for exactly one cycle, then go IDLE.
- Word order: word k of a block = rate_i[k*WORD_W +: WORD_W], k=0..WPB-1.
- Ignored inputs:
  - start_i outside IDLE.
  - rate_valid_i outside WAIT_BLOCK.
  - ready_i when valid_o=0.
- No arithmetic wrap: remaining never decrements below 1 (exit happens at 1). widx resets on each block load.

## Timing
- Reset (rst=0 at a clock edge):
  - state=IDLE.
  - valid_o=0, last_o=0, perm_req_o=0, busy_o=0, done_o=0.
  - data_o=0 (buf cleared), remaining=0, widx=0.
  - Reset mid-squeeze aborts the squeeze with no done_o.
- Outputs are combinational decodes of registered state only; there is no combinational path from ready_i to valid_o.
- busy_o=1 from the cycle after an accepted start_i until done_o deasserts.
- First valid_o: the cycle after rate_valid_i is sampled in WAIT_BLOCK.
- Throughput: one word per cycle while ready_i=1.
- Handshake hold: once valid_o=1, data_o and last_o hold stable until accepted.
- Block boundary:
  - perm_req_o pulses in the same cycle the WPB-th word is accepted.
  - valid_o is 0 from the next cycle until the next rate_valid_i.
- Completion: the final accept is followed by one DONE cycle, then IDLE. A new start_i is accepted in the cycle after done_o.
- Simultaneous events:
  - Final word of a block that is also the final word of the squeeze → DONE, and perm_req_o is NOT asserted.
  - start_i in the DONE cycle is ignored.

## Test plan
- Reset mid-EMIT: drive rst=0 on the third word → next cycle valid_o=0, busy_o=0, done_o=0. A subsequent start_i with out_len_i=2 works normally.
- Single word: start_i with out_len_i=1, rate_i word0=64'h0123_4567_89AB_CDEF, rate_valid_i one cycle later, ready_i=1:
  - valid_o=1 with last_o=1 and that data for one cycle.
  - perm_req_o never asserts.
  - done_o pulses one cycle after the accept.
- SHA3-256 digest: out_len_i=4, rate_i[k*64+:64]=k+1:
  - Words 1,2,3,4 emitted on consecutive cycles; last_o=1 only on the 4.
  - perm_req_o=0 throughout; done_o fires.
- SHAKE multi-block: out_len_i=40, each block's words tagged {block,k}:
  - perm_req_o pulses exactly twice, on the accept of words 17 and 34.
  - valid_o=0 while in WAIT_BLOCK.
  - Sequence of 40 words correct; last_o on word 40.
- Backpressure: out_len_i=5, ready_i toggled 1,0,0,1,0,1,1,1 → data_o/valid_o/last_o stable while ready_i=0; exactly 5 accepts, in order.
- Zero length / ignored inputs:
  - start_i with out_len_i=0 → done_o pulses, no valid_o and no perm_req_o.
  - start_i and rate_valid_i pulsed during EMIT → no effect on remaining or on the word sequence.
